// File: rtl/mips_pkg.sv
// Register-file widths and architectural register indices shared with decode and the write-address mux.
// No logic and no latency; no flow control.
package mips_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_AT   = 5'd1;
    localparam logic [ADDR_W-1:0] REG_V0   = 5'd2;
    localparam logic [ADDR_W-1:0] REG_A0   = 5'd4;
    localparam logic [ADDR_W-1:0] REG_T0   = 5'd8;
    localparam logic [ADDR_W-1:0] REG_S0   = 5'd16;
    localparam logic [ADDR_W-1:0] REG_GP   = 5'd28;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W-1:0] REG_FP   = 5'd30;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

    localparam logic [15:0] WCNT_MAX = 16'hFFFF;

    // $0 is hardwired: writes to it never commit and never forward.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// One read port's write-through forwarding: selects the in-flight write data on an address match.
// Purely combinational, zero latency; no backpressure.
module regfile_bypass #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              fwd_en,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadAddr,
    input  logic [DATA_W-1:0] stored_dat,
    output logic [DATA_W-1:0] ReadData
);

    logic hit;

    // fwd_en drops during reset so a write that will be discarded is never visible.
    always_comb begin
        hit = BYPASS_EN && fwd_en && RegWrite
              && (WriteAddr != '0) && (ReadAddr == WriteAddr);
        ReadData = hit ? WriteData : stored_dat;
    end

endmodule

// File: rtl/regfile_wb.sv
// 32x32 MIPS register file with two bypassed read ports, a raw debug port and a saturating write counter.
// Writes commit on the next rising edge; reads are combinational. No backpressure: every write is accepted.
module regfile_wb
    import mips_pkg::*;
#(
    parameter int DATA_W    = mips_pkg::DATA_W,
    parameter int ADDR_W    = mips_pkg::ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadAddr1,
    input  logic [ADDR_W-1:0] ReadAddr2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [DATA_W-1:0] DbgData,
    output logic [15:0]       WriteCount
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [15:0]       wr_cnt;
    logic              wr_commit;
    logic [DATA_W-1:0] rd1_stored_dat;
    logic [DATA_W-1:0] rd2_stored_dat;

    assign wr_commit = RegWrite && (WriteAddr != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wr_cnt <= '0;
        end else if (wr_commit) begin
            regs[WriteAddr] <= WriteData;
            if (wr_cnt != WCNT_MAX) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

    // $0 is forced to zero on read so it is clean even before the first reset.
    always_comb begin
        rd1_stored_dat = (ReadAddr1 == '0) ? '0 : regs[ReadAddr1];
        rd2_stored_dat = (ReadAddr2 == '0) ? '0 : regs[ReadAddr2];
        DbgData        = (DbgAddr   == '0) ? '0 : regs[DbgAddr];
    end

    regfile_bypass #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_byp1 (
        .fwd_en     (reset_n),
        .RegWrite   (RegWrite),
        .WriteAddr  (WriteAddr),
        .WriteData  (WriteData),
        .ReadAddr   (ReadAddr1),
        .stored_dat (rd1_stored_dat),
        .ReadData   (ReadData1)
    );

    regfile_bypass #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_byp2 (
        .fwd_en     (reset_n),
        .RegWrite   (RegWrite),
        .WriteAddr  (WriteAddr),
        .WriteData  (WriteData),
        .ReadAddr   (ReadAddr2),
        .stored_dat (rd2_stored_dat),
        .ReadData   (ReadData2)
    );

    assign WriteCount = wr_cnt;

endmodule
